// File: rtl/lfo_gen.sv
// Low-frequency oscillator: programmable-rate stepping of a WIDTH-bit value
// with ramp / triangle / sawtooth / square waveforms.
// Optional one-pole smoothing of the output is enabled by defining LFO_SMOOTH_EN.
//
// Handshake note: there is no valid/ready traffic here. clk_3MHz_en is a
// qualifier pulse, sync is a level sampled on every clk edge, and tick is a
// one-clk strobe marking the cycle a new raw value first appears on out.
module lfo_gen #(
   parameter int WIDTH        = 8,
   parameter int DIV_W        = 15,
   parameter int SMOOTH_SHIFT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_3MHz_en,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] rate,
   input  logic             dir_en,
   input  logic             sync,
   output logic [WIDTH-1:0] out,
   output logic             tick,
   output logic             at_min,
   output logic             at_max
);

   localparam logic [1:0] MODE_RAMP   = 2'b00;
   localparam logic [1:0] MODE_TRI    = 2'b01;
   localparam logic [1:0] MODE_SAW    = 2'b10;
   localparam logic [1:0] MODE_SQUARE = 2'b11;

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] presc;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] raw_next;
   logic             dir_down;
   logic             dir_next;
   logic             tri_down;
   logic             step;

   // A step fires on an enable once the prescaler has reached (or passed) the rate.
   assign step = clk_3MHz_en && (presc >= rate);

   // Waveform next-value and triangle direction, evaluated every cycle.
   always_comb begin
      raw_next = raw;
      dir_next = dir_down;
      // Extremes force the triangle direction so a mode change into TRIANGLE
      // at either rail never tries to step past it.
      tri_down = (raw == MAX_VAL) || ((raw != '0) && dir_down);
      case (mode)
         MODE_RAMP: begin
            if (!dir_en) begin
               if (raw != MAX_VAL) raw_next = raw + ONE_VAL;
            end else begin
               if (raw != '0) raw_next = raw - ONE_VAL;
            end
         end
         MODE_TRI: begin
            if (tri_down) begin
               raw_next = raw - ONE_VAL;
               dir_next = (raw != ONE_VAL);
            end else begin
               raw_next = raw + ONE_VAL;
               dir_next = (raw == (MAX_VAL - ONE_VAL));
            end
         end
         MODE_SAW: begin
            raw_next = raw + ONE_VAL;
         end
         MODE_SQUARE: begin
            raw_next = (raw == '0) ? MAX_VAL : '0;
         end
         default: begin
            raw_next = raw;
         end
      endcase
   end

   // Prescaler, raw value, direction flag and tick strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc    <= '0;
         raw      <= '0;
         dir_down <= 1'b0;
         tick     <= 1'b0;
      end else if (sync) begin
         presc    <= '0;
         raw      <= '0;
         dir_down <= 1'b0;
         tick     <= 1'b0;
      end else begin
         tick <= step;
         if (clk_3MHz_en) begin
            presc <= step ? '0 : presc + {{(DIV_W-1){1'b0}}, 1'b1};
         end
         if (step) begin
            raw      <= raw_next;
            dir_down <= dir_next;
         end
      end
   end

   assign at_min = (raw == '0);
   assign at_max = (raw == MAX_VAL);

`ifdef LFO_SMOOTH_EN
   localparam int ACC_W = WIDTH + SMOOTH_SHIFT;

   logic [ACC_W-1:0] acc;

   // One-pole low-pass of raw, updated on every enable; steady state acc>>SHIFT == raw.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (sync) begin
         acc <= '0;
      end else if (clk_3MHz_en) begin
         acc <= acc + {{SMOOTH_SHIFT{1'b0}}, raw} - (acc >> SMOOTH_SHIFT);
      end
   end

   assign out = acc[ACC_W-1:SMOOTH_SHIFT];
`else
   assign out = raw;
`endif

endmodule

// File: tb/tb_lfo_gen.sv
// Self-checking bench for lfo_gen (default build, WIDTH=8, DIV_W=15).
module tb_lfo_gen;

   logic        clk;
   logic        rst;
   logic        clk_3MHz_en;
   logic [1:0]  mode;
   logic [14:0] rate;
   logic        dir_en;
   logic        sync;
   logic [7:0]  out;
   logic        tick;
   logic        at_min;
   logic        at_max;

   int n_tests;
   int n_fail;
   int tick_cnt;

   // Model state: value, enables since last step, triangle phase (0..509), tick.
   int m_raw;
   int m_cnt;
   int m_phase;
   int m_tick;

   lfo_gen #(.WIDTH(8), .DIV_W(15), .SMOOTH_SHIFT(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_3MHz_en (clk_3MHz_en),
      .mode        (mode),
      .rate        (rate),
      .dir_en      (dir_en),
      .sync        (sync),
      .out         (out),
      .tick        (tick),
      .at_min      (at_min),
      .at_max      (at_max)
   );

   // Clock and reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int tri_val(input int ph);
      return (ph <= 255) ? ph : 510 - ph;
   endfunction

   // Behavioural model: triangle as a 510-long phase, ramp as a clamp,
   // saw as modulo-256, square as a toggle between rails.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_raw = 0; m_cnt = 0; m_phase = 0; m_tick = 0;
      end else begin
         m_tick = 0;
         if (sync) begin
            m_raw = 0; m_cnt = 0; m_phase = 0;
         end else if (clk_3MHz_en) begin
            if (m_cnt >= int'(rate)) begin
               m_cnt  = 0;
               m_tick = 1;
               case (mode)
                  2'b00: m_raw = dir_en ? ((m_raw > 0) ? m_raw - 1 : 0)
                                        : ((m_raw < 255) ? m_raw + 1 : 255);
                  2'b01: begin
                     if (tri_val(m_phase) != m_raw) m_phase = m_raw;
                     m_phase = (m_phase + 1) % 510;
                     m_raw   = tri_val(m_phase);
                  end
                  2'b10: m_raw = (m_raw + 1) % 256;
                  default: m_raw = (m_raw == 0) ? 255 : 0;
               endcase
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   end

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      n_tests++;
      if (out !== 8'(m_raw) || tick !== 1'(m_tick) ||
          at_min !== (m_raw == 0) || at_max !== (m_raw == 255)) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t out=%0d tick=%b min=%b max=%b required out=%0d tick=%0d",
                  $time, out, tick, at_min, at_max, m_raw, m_tick);
      end
      if (tick === 1'b1) tick_cnt++;
   end

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d required=%0d", name, got, exp);
      end
   endtask

   // Driver tasks: each enable is one cycle high followed by one cycle low.
   task automatic en_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         clk_3MHz_en = 1'b1;
         @(posedge clk); #2;
         clk_3MHz_en = 1'b0;
         @(posedge clk); #2;
      end
   endtask

   task automatic do_sync();
      sync = 1'b1;
      @(posedge clk); #2;
      sync = 1'b0;
   endtask

   initial begin
      n_tests = 0; n_fail = 0; tick_cnt = 0;
      rst = 1'b1; clk_3MHz_en = 1'b0; mode = 2'b00; rate = '0; dir_en = 1'b0; sync = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_out", out, 0);
      chk("reset_at_min", at_min, 1);
      chk("reset_at_max", at_max, 0);
      chk("reset_tick", tick, 0);
      rst = 1'b0;
      @(posedge clk); #2;

      // RAMP up, saturate, then down to 0 and hold
      en_pulses(254);
      chk("ramp_254", out, 254);
      chk("ramp_254_max", at_max, 0);
      en_pulses(1);
      chk("ramp_255", out, 255);
      chk("ramp_255_max", at_max, 1);
      en_pulses(45);
      chk("ramp_hold", out, 255);
      dir_en = 1'b1;
      en_pulses(254);
      chk("ramp_down_1", out, 1);
      en_pulses(1);
      chk("ramp_down_0", out, 0);
      chk("ramp_down_min", at_min, 1);
      en_pulses(5);
      chk("ramp_down_hold", out, 0);
      dir_en = 1'b0;

      // TRIANGLE, rate=2: step every 3rd enable, period 1530 enables
      mode = 2'b01; rate = 15'd2;
      do_sync();
      tick_cnt = 0;
      en_pulses(2);
      chk("tri_no_step_yet", out, 0);
      en_pulses(1);
      chk("tri_first_step", out, 1);
      en_pulses(762);
      chk("tri_peak", out, 255);
      en_pulses(3);
      chk("tri_after_peak", out, 254);
      en_pulses(762);
      chk("tri_period_end", out, 0);
      chk("tri_tick_count", tick_cnt, 510);

      // SAW wrap, then SQUARE toggling
      mode = 2'b10; rate = '0;
      do_sync();
      en_pulses(255);
      chk("saw_255", out, 255);
      en_pulses(1);
      chk("saw_wrap", out, 0);
      mode = 2'b11;
      en_pulses(1);
      chk("sq_hi", out, 255);
      en_pulses(1);
      chk("sq_lo", out, 0);
      en_pulses(1);
      chk("sq_hi2", out, 255);

      // Rate lowered below current prescaler count
      mode = 2'b10; rate = 15'd100;
      do_sync();
      en_pulses(50);
      chk("rate_pre", out, 0);
      rate = 15'd10;
      en_pulses(1);
      chk("rate_immediate_step", out, 1);
      en_pulses(10);
      chk("rate_wait10", out, 1);
      en_pulses(1);
      chk("rate_11th", out, 2);

      // sync coincident with a step at raw=77
      rate = '0;
      do_sync();
      en_pulses(77);
      chk("sync_pre77", out, 77);
      sync = 1'b1; clk_3MHz_en = 1'b1;
      @(posedge clk); #2;
      sync = 1'b0; clk_3MHz_en = 1'b0;
      chk("sync_out", out, 0);
      chk("sync_tick", tick, 0);
      rate = 15'd3;
      en_pulses(3);
      chk("sync_wait3", out, 0);
      en_pulses(1);
      chk("sync_step4", out, 1);

      // Asynchronous reset between edges
      rate = '0;
      en_pulses(5);
      chk("pre_rst", out, 6);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out", out, 0);
      chk("async_rst_min", at_min, 1);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
